// File: rtl/chunked_adder.sv
// ----------------------------------------------------------------------------
// chunked_adder
//
// Multi-cycle adder/subtractor. Adds two WIDTH-bit operands CHUNK bits per
// clock. This reduces the carry chain to CHUNK bits, at the cost of N cycles
// per operation.
//
// An operation is accepted in IDLE on an edge where start=1. That edge is
// edge 0. The block then spends N edges in RUN, processing one chunk per
// edge. It spends one edge in DONE. The done pulse is a registered copy of
// the DONE state, so it is first high in the cycle after edge N+1. The
// results are stable by then.
//
// Parameters
//   WIDTH    operand/result width in bits
//   CHUNK    bits processed per cycle. WIDTH must be a multiple of CHUNK.
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous active-high reset, overrides everything
//   start    request, honoured only while idle
//   a, b     operands, captured on the accepting edge
//   cin      carry-in for add mode. Ignored when subtracting.
//   sub      0: a + b + cin   1: a - b
//   busy     operation in progress (state is RUN or DONE)
//   done     one-cycle pulse: sum/cout/overflow are valid
//   sum      result. Held until the next accepted start.
//   cout     carry out of bit WIDTH-1
//   overflow two's-complement signed overflow
// ----------------------------------------------------------------------------
module chunked_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_r;
    state_t           state_next_s;

    // Captured operands; b_r already holds b' (b or ~b depending on mode).
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             carry_r;
    logic [KW-1:0]    k_r;

    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             overflow_r;

    logic [CHUNK-1:0] a_chunk_s;
    logic [CHUNK-1:0] b_chunk_s;
    logic [CHUNK-1:0] chunk_sum_s;
    logic             chunk_cout_s;
    logic             accept_s;
    logic             last_s;
    logic             ovf_next_s;

    // Chunk adder: slice k of both operands plus the running carry.
    always_comb begin
        a_chunk_s = a_r[k_r*CHUNK +: CHUNK];
        b_chunk_s = b_r[k_r*CHUNK +: CHUNK];
        {chunk_cout_s, chunk_sum_s} = {1'b0, a_chunk_s}
                                    + {1'b0, b_chunk_s}
                                    + {{CHUNK{1'b0}}, carry_r};
        last_s = (k_r == K_LAST);
        // Only meaningful on the last chunk, which holds bit WIDTH-1.
        ovf_next_s = (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                     (chunk_sum_s[CHUNK-1] != a_r[WIDTH-1]);
    end

    // Next-state logic and the accept strobe.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    accept_s     = 1'b1;
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register plus the registered busy/done status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != IDLE);
            done_r  <= (state_r == DONE);
        end
    end

    // Operand capture, chunk accumulation and final flag computation.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r        <= {WIDTH{1'b0}};
            b_r        <= {WIDTH{1'b0}};
            carry_r    <= 1'b0;
            k_r        <= {KW{1'b0}};
            sum_r      <= {WIDTH{1'b0}};
            cout_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else if (accept_s) begin
            // Subtraction is a + ~b + 1, so cin is replaced by a forced 1.
            a_r     <= a;
            b_r     <= sub ? ~b : b;
            carry_r <= sub ? 1'b1 : cin;
            k_r     <= {KW{1'b0}};
        end else if (state_r == RUN) begin
            sum_r[k_r*CHUNK +: CHUNK] <= chunk_sum_s;
            carry_r                   <= chunk_cout_s;
            if (last_s) begin
                k_r        <= {KW{1'b0}};
                cout_r     <= chunk_cout_s;
                overflow_r <= ovf_next_s;
            end else begin
                k_r        <= k_r + KW'(1);
            end
        end else begin
            // Results hold outside RUN.
            sum_r      <= sum_r;
            cout_r     <= cout_r;
            overflow_r <= overflow_r;
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign sum      = sum_r;
    assign cout     = cout_r;
    assign overflow = overflow_r;

endmodule

// File: doc/chunked_adder.md
CHUNKED_ADDER -- requirements
Module: chunked_adder

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits.
REQ-002 Parameter CHUNK, default 8: bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK; N = WIDTH/CHUNK.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request; accepted only in IDLE.
REQ-006 a  input  WIDTH  operand A, sampled on the accepting edge.
REQ-007 b  input  WIDTH  operand B, sampled on the accepting edge.
REQ-008 cin  input  1  carry-in for add mode, sampled on the accepting edge.
REQ-009 sub  input  1  mode (0 = A+B+cin, 1 = A-B), sampled on the accepting edge.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 done  output  1  one-cycle pulse marking valid results.
REQ-012 sum  output  WIDTH  result.
REQ-013 cout  output  1  carry out of bit WIDTH-1.
REQ-014 overflow  output  1  two's-complement signed overflow.

Function
REQ-015 FSM states: IDLE, RUN, DONE.
REQ-016 IDLE with start=1 at an edge: capture a, b' and carry, clear chunk index to 0, go to RUN.
REQ-017 b' = b when sub=0, ~b when sub=1.
REQ-018 Initial carry = cin when sub=0, 1 when sub=1 (cin ignored).
REQ-019 RUN: each edge adds chunk k of A, chunk k of b' and the carry register; writes CHUNK bits into sum[k*CHUNK +: CHUNK]; stores the chunk carry-out; increments k.
REQ-020 RUN: on the edge processing chunk N-1, go to DONE; exactly N edges spent in RUN.
REQ-021 Entering DONE: cout = final chunk carry-out; overflow = (A[WIDTH-1] == b'[WIDTH-1]) AND (sum[WIDTH-1] != A[WIDTH-1]).
REQ-022 DONE lasts one cycle with done=1, then IDLE unconditionally.
REQ-023 done is first high in the cycle after the (N+1)th edge counted from the accepting edge (accepting edge = edge 0).
REQ-024 start while busy=1 (RUN or DONE) SHALL be ignored: no operand capture, no effect on the current operation.
REQ-025 Operand inputs may change after the accepting edge without affecting the result.
REQ-026 sum, cout and overflow SHALL hold their values from DONE until the next accepted start.
REQ-027 After an accepted start, sum SHALL NOT be read as valid until done.
REQ-028 Carry propagation wraps out of bit WIDTH-1 only into cout; there is no modular carry back into bit 0.
REQ-029 N=1 (CHUNK=WIDTH) SHALL work: one RUN cycle, then DONE.

Reset
REQ-030 rst=1 at an edge SHALL force: state IDLE, k=0, carry register 0, busy=0, done=0, sum=0, cout=0, overflow=0.
REQ-031 rst has priority over start and over every FSM transition, including an abort during RUN or DONE.
REQ-032 A start asserted in the same cycle as rst SHALL be discarded.

Verification (WIDTH=32, CHUNK=8, N=4)
REQ-033 Add carry ripple:
- stimulus: a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0, start pulse at edge 0.
- response: busy=1 from edge 0; done=1 only after edge 5; sum=0x00000000, cout=1, overflow=0.
REQ-034 Signed overflow:
- stimulus: a=0x7FFFFFFF, b=0x00000001, sub=0.
- response: sum=0x80000000, cout=0, overflow=1.
REQ-035 Subtract:
- stimulus: a=5, b=7, sub=1, cin=1 (cin ignored).
- response: sum=0xFFFFFFFE, cout=0, overflow=0.
- also a=7, b=5: sum=2, cout=1.
REQ-036 Start while busy:
- stimulus: second start (a=1, b=1) at edge 2 of an operation computing 0x10+0x20.
- response: sum=0x30; exactly one done pulse; busy low after done.
REQ-037 Reset mid-operation:
- stimulus: rst at edge 2 of RUN.
- response: next cycle busy=0, done=0, sum=0; no done pulse ever follows.
- response: a fresh start then completes normally.
REQ-038 Degenerate configuration:
- stimulus: WIDTH=CHUNK=32, a=0x80000000, b=0x80000000.
- response: done after edge 2; sum=0, cout=1, overflow=1.
